operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Register-read pipeline stage that sits between instruction decode and execute, wrapped around the synchronous-read register file.
- Drives the register file read addresses and captures the operand data, which the register file returns one cycle later.
- Bypasses same-cycle writebacks, because the register file returns old data on a same-cycle read/write collision.
- Forces x0 to zero and presents {pc, instr, rs1_val, rs2_val} to execute behind a valid/ready handshake.

Parameters:
- XLEN, 32, width of PC, instruction and register data.
- ZERO_X0, 1, when 1 the operand value for address 0 is forced to 0 regardless of register file contents.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the held entry and of any same-cycle accept.
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  XLEN  instruction word; rs1 = [19:15], rs2 = [24:20].
- in_pc  in  XLEN  instruction PC.
- addr_rs1  out  5  register file read address 1 (combinational).
- addr_rs2  out  5  register file read address 2 (combinational).
- R_data_rs1  in  XLEN  register file read data 1, valid one cycle after the address.
- R_data_rs2  in  XLEN  register file read data 2.
- wb_enable  in  1  writeback strobe; same signal that drives the register file write_enable.
- wb_addr  in  5  writeback address (register file addr_rd).
- wb_data  in  XLEN  writeback data (register file data_rd).
- out_valid  out  1  operands valid to execute.
- out_ready  in  1  execute accepts.
- out_pc  out  XLEN  held PC.
- out_instr  out  XLEN  held instruction.
- out_rs1_val  out  XLEN  resolved rs1 operand.
- out_rs2_val  out  XLEN  resolved rs2 operand.

Behaviour:
- Reset (async, reset_n=0): state EMPTY; out_valid=0; out_pc=0, out_instr=0; forward flags cleared, so out_rs*_val show R_data or 0.
- States: EMPTY (no held entry) and FULL (held entry).
  - in_ready = EMPTY or out_ready, combinationally.
  - accept = in_valid & in_ready & !flush.
- Transitions:
  - EMPTY->FULL on accept.
  - FULL->FULL on out_ready & accept.
  - FULL->EMPTY on out_ready & !accept, or on flush.
  - FULL holds while !out_ready.
- Address mux:
  - On an accept cycle, addr_rs1/addr_rs2 come from in_instr.
  - Otherwise they come from the held out_instr, so the register file re-reads every stalled cycle and operands track later writes.
- Latency: instruction accepted at edge N gives out_valid=1 in cycle N+1 with operands.
- Forwarding, evaluated per read port every cycle:
  - fwd_hit = wb_enable & (wb_addr == issued addr) & (issued addr != 0).
  - On the next edge, register fwd_flag <= fwd_hit and fwd_data <= wb_data.
  - Operand = (ZERO_X0 & held addr==0) ? 0 : fwd_flag ? fwd_data : R_data.
- A writeback one or more cycles before the read is already visible in R_data; no forwarding is needed.
- Writes to x0 are never forwarded.
- flush: clears out_valid at the next edge and blocks accept in the same cycle (flush wins over in_valid). in_ready is unaffected.
- Output registers update only on accept; no bubble insertion while out_ready=1 and in_valid is streaming.
- Throughput: one instruction per cycle.
- Reset asserted mid-stall: entry dropped immediately; out_valid falls asynchronously.

Test Plan:
- Reset, then in_instr=0x00208033 (add x0,x1,x2), x1=5, x2=7 preloaded -> next cycle out_valid=1, out_rs1_val=5, out_rs2_val=7, in_ready=1.
- Same-cycle collision: accept an instruction with rs1=x3 while wb_enable=1, wb_addr=3, wb_data=0xDEADBEEF (old x3=0) -> out_rs1_val=0xDEADBEEF.
- Stall: hold out_ready=0 for 3 cycles with x5=1. Write x5=0x22 in stall cycle 2 -> in_ready=0 during the stall; out_rs?_val for x5 becomes 0x22 by the cycle after the write; accepted on release.
- x0: rs1=rs2=0, register file returning 0xFFFFFFFF at addr 0, and wb to x0 with 0x1234 -> both operands 0.
- Back-to-back stream of 4 instructions with out_ready=1 -> out_valid continuously 1, each operand set correct, no dropped or duplicated PCs.
- flush asserted together with in_valid while FULL -> next cycle out_valid=0, input instruction not captured. Separately, reset_n pulsed while FULL -> out_valid=0 immediately.

Source files
------------

// File: rtl/operand_fetch.sv
// Register-read stage between decode and execute: drives the synchronous-read register
// file, bypasses same-cycle writebacks and holds {pc, instr, rs1, rs2} behind valid/ready.
module operand_fetch #(
    parameter int XLEN    = 32,
    parameter int ZERO_X0 = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      addr_rs1,
    output logic [4:0]      addr_rs2,
    input  logic [XLEN-1:0] R_data_rs1,
    input  logic [XLEN-1:0] R_data_rs2,
    input  logic            wb_enable,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_p1;
    logic            vld_p1;
    logic [XLEN-1:0] pc_p1;
    logic [XLEN-1:0] instr_p1;

    logic            accept_p0;
    logic            fwd_hit_rs1_p0;
    logic            fwd_hit_rs2_p0;
    logic            fwd_flag_rs1_p1;
    logic            fwd_flag_rs2_p1;
    logic [XLEN-1:0] fwd_data_rs1_p1;
    logic [XLEN-1:0] fwd_data_rs2_p1;

    // x0 forcing beats the bypass, which beats the register file's (possibly stale) data
    function automatic logic [XLEN-1:0] resolve_operand(
        input logic [4:0]      addr,
        input logic            flag,
        input logic [XLEN-1:0] fdata,
        input logic [XLEN-1:0] rdata
    );
        if ((ZERO_X0 != 0) && (addr == 5'd0)) begin
            return '0;
        end
        return flag ? fdata : rdata;
    endfunction

    // ---- p0: handshake, read-address mux and collision detect
    assign in_ready  = (state_p1 == EMPTY) || out_ready;
    assign accept_p0 = in_valid && in_ready && !flush;

    // Stalled entries keep re-reading so their operands follow later writebacks
    assign addr_rs1 = accept_p0 ? in_instr[19:15] : instr_p1[19:15];
    assign addr_rs2 = accept_p0 ? in_instr[24:20] : instr_p1[24:20];

    assign fwd_hit_rs1_p0 = wb_enable && (wb_addr == addr_rs1) && (addr_rs1 != 5'd0);
    assign fwd_hit_rs2_p0 = wb_enable && (wb_addr == addr_rs2) && (addr_rs2 != 5'd0);

    // ---- p1: held entry and bypass registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_p1 <= EMPTY;
            vld_p1   <= 1'b0;
            pc_p1    <= '0;
            instr_p1 <= '0;
        end else if (accept_p0) begin
            state_p1 <= FULL;
            vld_p1   <= 1'b1;
            pc_p1    <= in_pc;
            instr_p1 <= in_instr;
        end else if ((state_p1 == FULL) && (out_ready || flush)) begin
            state_p1 <= EMPTY;
            vld_p1   <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fwd_flag_rs1_p1 <= 1'b0;
            fwd_flag_rs2_p1 <= 1'b0;
        end else begin
            fwd_flag_rs1_p1 <= fwd_hit_rs1_p0;
            fwd_flag_rs2_p1 <= fwd_hit_rs2_p0;
        end
    end

    always_ff @(posedge clock) begin
        fwd_data_rs1_p1 <= wb_data;
        fwd_data_rs2_p1 <= wb_data;
    end

    assign out_valid   = vld_p1;
    assign out_pc      = pc_p1;
    assign out_instr   = instr_p1;
    assign out_rs1_val = resolve_operand(instr_p1[19:15], fwd_flag_rs1_p1, fwd_data_rs1_p1, R_data_rs1);
    assign out_rs2_val = resolve_operand(instr_p1[24:20], fwd_flag_rs2_p1, fwd_data_rs2_p1, R_data_rs2);

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a synchronous-read register file model feeds the DUT, and a
// one-entry architectural model predicts handshake, held entry and operand values.
module tb_operand_fetch;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  addr_rs1;
    logic [4:0]  addr_rs2;
    logic [31:0] R_data_rs1 = '0;
    logic [31:0] R_data_rs2 = '0;
    logic        wb_enable = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;

    operand_fetch #(.XLEN(32), .ZERO_X0(1)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
        .R_data_rs1(R_data_rs1), .R_data_rs2(R_data_rs2),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val)
    );

    always #5 clock = ~clock;

    // Register file: read data appears one cycle after the address, old data on collision
    logic [31:0] mem [0:31];
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else begin
            R_data_rs1 <= mem[addr_rs1];
            R_data_rs2 <= mem[addr_rs2];
            if (wb_enable) mem[wb_addr] <= wb_data;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    // Reference state: one-entry buffer holding the last accepted instruction
    logic        m_full = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] pc_ctr = 32'h8000;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] r1, input logic [4:0] r2);
        return {7'd0, r2, r1, 3'd0, 5'd0, 7'h33};
    endfunction

    // Architectural value of a register: x0 reads as zero, others as the latest write
    function automatic logic [31:0] arch_val(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mem[a];
    endfunction

    // Called just after a falling edge with inputs already driven; returns after the next one
    task automatic cycle();
        logic        exp_ready;
        logic        exp_acc;
        logic [31:0] src;
        #1;
        exp_ready = !m_full || out_ready;
        exp_acc   = in_valid && exp_ready && !flush;
        src       = exp_acc ? in_instr : m_instr;
        check_val("in_ready", 32'(in_ready), 32'(exp_ready));
        check_val("addr_rs1", 32'(addr_rs1), 32'(src[19:15]));
        check_val("addr_rs2", 32'(addr_rs2), 32'(src[24:20]));
        @(posedge clock);
        if (exp_acc) begin
            m_full  = 1'b1;
            m_pc    = in_pc;
            m_instr = in_instr;
        end else if (out_ready || flush) begin
            m_full = 1'b0;
        end
        @(negedge clock);
        check_val("out_valid", 32'(out_valid), 32'(m_full));
        check_val("out_pc", out_pc, m_pc);
        check_val("out_instr", out_instr, m_instr);
        check_val("out_rs1_val", out_rs1_val, arch_val(m_instr[19:15]));
        check_val("out_rs2_val", out_rs2_val, arch_val(m_instr[24:20]));
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        wb_enable = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_enable = 1'b1;
        wb_addr   = a;
        wb_data   = d;
        cycle();
        wb_enable = 1'b0;
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = mk_instr(r1, r2);
        in_pc    = pc;
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_async_valid", 32'(out_valid), 32'd0);
        check_val("rst_async_pc", out_pc, 32'd0);
        reset_n = 1'b1;
        m_full  = 1'b0;
        m_pc    = '0;
        m_instr = '0;
        @(negedge clock);
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check_val("reset_valid", 32'(out_valid), 32'd0);
        check_val("reset_pc", out_pc, 32'd0);
        check_val("reset_instr", out_instr, 32'd0);
        check_val("reset_in_ready", 32'(in_ready), 32'd1);

        // add x0,x1,x2 with x1=5, x2=7
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd7);
        in_valid = 1'b1;
        in_instr = 32'h00208033;
        in_pc    = 32'h1000;
        cycle();
        in_valid = 1'b0;
        check_val("add_valid", 32'(out_valid), 32'd1);
        check_val("add_rs1", out_rs1_val, 32'd5);
        check_val("add_rs2", out_rs2_val, 32'd7);
        check_val("add_in_ready", 32'(in_ready), 32'd1);
        cycle();

        // Same-cycle write to the register being read
        wb_write(5'd3, 32'd0);
        issue(5'd3, 5'd0, 32'h1004);
        wb_enable = 1'b1;
        wb_addr   = 5'd3;
        wb_data   = 32'hDEADBEEF;
        cycle();
        idle();
        check_val("collide_rs1", out_rs1_val, 32'hDEADBEEF);
        cycle();

        // Stall with a write to the held source register
        wb_write(5'd5, 32'd1);
        issue(5'd5, 5'd5, 32'h1008);
        cycle();
        check_val("stall_rs1_pre", out_rs1_val, 32'd1);
        out_ready = 1'b0;
        issue(5'd1, 5'd2, 32'h100C);
        cycle();
        check_val("stall1_in_ready", 32'(in_ready), 32'd0);
        wb_enable = 1'b1;
        wb_addr   = 5'd5;
        wb_data   = 32'h22;
        cycle();
        wb_enable = 1'b0;
        check_val("stall2_in_ready", 32'(in_ready), 32'd0);
        check_val("stall_rs1_upd", out_rs1_val, 32'h22);
        check_val("stall_rs2_upd", out_rs2_val, 32'h22);
        cycle();
        check_val("stall3_pc", out_pc, 32'h1008);
        out_ready = 1'b1;
        cycle();
        check_val("release_pc", out_pc, 32'h100C);
        check_val("release_valid", 32'(out_valid), 32'd1);
        idle();
        cycle();

        // x0 forced to zero despite register file contents and a same-cycle write
        wb_write(5'd0, 32'hFFFFFFFF);
        issue(5'd0, 5'd0, 32'h1010);
        wb_enable = 1'b1;
        wb_addr   = 5'd0;
        wb_data   = 32'h1234;
        cycle();
        idle();
        check_val("x0_rs1", out_rs1_val, 32'd0);
        check_val("x0_rs2", out_rs2_val, 32'd0);
        cycle();

        // Back-to-back stream
        for (int i = 0; i < 4; i++) begin
            issue(5'(i + 1), 5'(4 - i), 32'h2000 + 32'(4 * i));
            cycle();
            check_val("stream_valid", 32'(out_valid), 32'd1);
            check_val("stream_pc", out_pc, 32'h2000 + 32'(4 * i));
        end
        idle();
        cycle();
        check_val("stream_drain", 32'(out_valid), 32'd0);

        // Flush while FULL with a competing input
        issue(5'd1, 5'd2, 32'h3000);
        cycle();
        out_ready = 1'b0;
        flush     = 1'b1;
        issue(5'd2, 5'd1, 32'h3004);
        cycle();
        flush = 1'b0;
        check_val("flush_valid", 32'(out_valid), 32'd0);
        check_val("flush_pc", out_pc, 32'h3000);

        // Asynchronous reset while stalled
        out_ready = 1'b1;
        issue(5'd3, 5'd4, 32'h3008);
        cycle();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        cycle();
        check_val("pre_rst_valid", 32'(out_valid), 32'd1);
        pulse_reset();

        // Randomised traffic over a small register set so collisions are frequent
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] w;
            w        = $urandom;
            w[19:15] = 5'($urandom_range(0, 4));
            w[24:20] = 5'($urandom_range(0, 4));
            in_instr = w;
            in_valid = ($urandom_range(0, 3) != 0);
            in_pc    = pc_ctr;
            pc_ctr   = pc_ctr + 32'd4;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_enable = ($urandom_range(0, 1) != 0);
            wb_addr   = 5'($urandom_range(0, 4));
            wb_data   = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
